local_port_fifo: RTL and testbench
==================================

# local_port_fifo

Router local-input-port buffer sitting directly downstream of a PE injector. It accepts packets from the injector over the Req/Gnt handshake and reports its fill state on `Full`, which feeds the injector's `DnStrFull`. Buffered packets are stored in order and offered to the router's local-port arbiter/crossbar through a second Req/Gnt handshake. It is the router's entry point for traffic generated by the attached module.

## Interface
- `packetwidth`, 56, packet bus width (injector payload `{PacketID[9:0], ModuleID[5:0], RandomInfo[9:0]}` zero-extended in the upper bits)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `ADDR_W`, 2, log2(DEPTH)
- `clk` input 1: single clock, all logic on posedge
- `reset` input 1: asynchronous, active-low; clears all state immediately
- `ReqUpStr` input 1: injector request; `PacketIn` is valid and stable while high
- `PacketIn` input packetwidth: packet from injector
- `GntUpStr` output 1: one-cycle grant pulse; packet has been written
- `Full` output 1: occupancy == DEPTH (to injector `DnStrFull`)
- `ReqDnStr` output 1: head packet is available for the router
- `PacketOut` output packetwidth: head-of-FIFO packet
- `GntDnStr` input 1: router grant; head is consumed on the edge it is sampled with `ReqDnStr`
- `Occupancy` output ADDR_W+1: current entry count
- `PktInCnt` output 16: accepted-packet counter (see Configuration)
- `PktOutCnt` output 16: forwarded-packet counter (see Configuration)

## Operation
- Storage: `DEPTH`×`packetwidth` array, `wr_ptr`/`rd_ptr` (`ADDR_W` bits, wrap modulo DEPTH), `count` (`ADDR_W+1` bits).
- Upstream FSM with states `UP_IDLE` and `UP_GNT`:
  - `UP_IDLE`: on an edge with `ReqUpStr=1` and `count<DEPTH`, write `PacketIn` at `wr_ptr`, increment `wr_ptr`, and go to `UP_GNT`. Otherwise stay.
  - `UP_GNT`: `GntUpStr=1`. The next edge always returns to `UP_IDLE`. No write occurs in this state, even though `ReqUpStr` is still high.
- Downstream side:
  - `ReqDnStr = (count!=0)`.
  - `PacketOut = mem[rd_ptr]`. When empty it holds the last value; it is zero after reset.
  - Pop on an edge with `ReqDnStr & GntDnStr`: increment `rd_ptr`.
- `count` update on each edge: +1 on write only, −1 on pop only, unchanged on both or neither.
- Full is evaluated on pre-edge `count`. A push is refused while `count==DEPTH`, even if a pop happens in the same cycle; it is accepted on a later edge.
- `GntDnStr` while empty is ignored.
- Reset values: `GntUpStr=0`, `Full=0`, `ReqDnStr=0`, `PacketOut=0`, `Occupancy=0`, `PktInCnt=0`, `PktOutCnt=0`, FSM=`UP_IDLE`, pointers 0.
- Reset asserted mid-operation discards all stored packets and any pending grant.

## Timing
- Write edge T: `GntUpStr` is high for cycle T..T+1 only. `ReqDnStr`, `Occupancy` and `Full` reflect the new entry immediately after T.
- Injector drops `ReqUpStr` on the edge it samples the grant. Maximum accept rate is one packet per 2 cycles.
- Fall-through latency: a packet written at edge T can be popped at edge T+1.
- Router pop at edge P: the next entry appears on `PacketOut` after P; `Full` deasserts after P if the FIFO was full.
- Outputs `GntUpStr` and `count` are registered. `ReqDnStr`, `Full` and `PacketOut` decode from registers only, with no input-to-output combinational path.

## Configuration
- `LOCAL_FIFO_STATS_EN` defined:
  - `PktInCnt` increments on every write and `PktOutCnt` on every pop.
  - Both are 16-bit, wrap 0xFFFF→0, and clear on reset.
- `LOCAL_FIFO_STATS_EN` undefined: counter logic is omitted and both ports are tied to 0. Ports are always present.

## Test plan
- Reset, then a single request with `PacketIn=0x...0401_0A00`, `GntDnStr=0`: `GntUpStr` pulses exactly one cycle after the write edge; `ReqDnStr=1`; `PacketOut` equals the input; `Occupancy=1`.
- Four back-to-back injector packets, IDs 1–4, no router grants: four grants, each ≥2 cycles apart; `Full=1` after the 4th; a 5th request receives no grant until `GntDnStr` pops once, then is granted on a later edge.
- Drain with `GntDnStr` held high: packets emerge in order 1,2,3,4 on consecutive edges; `ReqDnStr` drops after the 4th pop; `Occupancy=0`.
- Simultaneous push and pop at `Occupancy=2`: `Occupancy` stays 2; the data order is preserved across pointer wrap (push 6 packets through DEPTH=4).
- `reset` pulsed low asynchronously mid-cycle with 3 entries and `GntUpStr` high: all outputs are immediately at their reset values, and the next accepted packet appears as head.
- With `LOCAL_FIFO_STATS_EN`: after 10 pushes and 7 pops, `PktInCnt=10` and `PktOutCnt=7`. Without the macro, both read 0.

Source files
------------

// File: rtl/local_port_fifo.sv
// Purpose: router local-input-port FIFO between a PE injector (Req/Gnt in) and the local arbiter (Req/Gnt out).
// Latency: a packet written at edge T is visible on PacketOut/ReqDnStr after T and can be popped at edge T+1.
// Backpressure: Full (count==DEPTH, pre-edge) refuses pushes; at most one accept per 2 cycles; optional stats via LOCAL_FIFO_STATS_EN.
module local_port_fifo #(
   parameter int packetwidth = 56,
   parameter int DEPTH       = 4,
   parameter int ADDR_W      = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ReqUpStr,
   input  logic [packetwidth-1:0] PacketIn,
   output logic                   GntUpStr,
   output logic                   Full,
   output logic                   ReqDnStr,
   output logic [packetwidth-1:0] PacketOut,
   input  logic                   GntDnStr,
   output logic [ADDR_W:0]        Occupancy,
   output logic [15:0]            PktInCnt,
   output logic [15:0]            PktOutCnt
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   typedef enum logic {UP_IDLE, UP_GNT} up_state_t;

   up_state_t              r_state;
   up_state_t              w_state_nxt;
   logic                   w_wr_en;
   logic                   w_pop;
   logic [packetwidth-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]      r_wr_ptr;
   logic [ADDR_W-1:0]      r_rd_ptr;
   logic [ADDR_W:0]        r_count;
   logic [packetwidth-1:0] r_last;

   // Full is judged on the pre-edge count, so a same-edge pop never frees room for a push.
   assign Full      = (r_count == LP_DEPTH);
   assign ReqDnStr  = (r_count != '0);
   assign w_pop     = ReqDnStr & GntDnStr;
   assign GntUpStr  = (r_state == UP_GNT);
   assign Occupancy = r_count;
   // When empty, show the last popped packet (zero out of reset) instead of a stale slot.
   assign PacketOut = ReqDnStr ? r_mem[r_rd_ptr] : r_last;

   // Upstream FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= UP_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Upstream FSM: accept in IDLE when room, then spend one cycle granting (no write there).
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      case (r_state)
         UP_IDLE: begin
            if (ReqUpStr && !Full) begin
               w_wr_en     = 1'b1;
               w_state_nxt = UP_GNT;
            end
         end
         UP_GNT:  w_state_nxt = UP_IDLE;
         default: w_state_nxt = UP_IDLE;
      endcase
   end

   // Packet storage; contents are don't-care until written, validity is tracked by r_count.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= PacketIn;
   end

   // Pointers, occupancy and the held-output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef LOCAL_FIFO_STATS_EN
   logic [15:0] r_in_cnt;
   logic [15:0] r_out_cnt;

   // Free-running accept/forward counters, wrapping at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_wr_en) r_in_cnt  <= r_in_cnt + 1'b1;
         if (w_pop)   r_out_cnt <= r_out_cnt + 1'b1;
      end
   end

   assign PktInCnt  = r_in_cnt;
   assign PktOutCnt = r_out_cnt;
`else
   assign PktInCnt  = '0;
   assign PktOutCnt = '0;
`endif

endmodule

// File: tb/tb_local_port_fifo.sv
// Purpose: bench for local_port_fifo against a queue-based packet model.
// Latency: outputs compared each cycle on the falling edge, inputs driven on the falling edge.
// Backpressure: model refuses pushes when holding DEPTH packets or right after an accept.
module tb_local_port_fifo;
   localparam int PW = 56;
   localparam int DEPTH = 4;
`ifdef LOCAL_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ReqUpStr = 1'b0;
   logic [PW-1:0] PacketIn = '0;
   logic          GntUpStr;
   logic          Full;
   logic          ReqDnStr;
   logic [PW-1:0] PacketOut;
   logic          GntDnStr = 1'b0;
   logic [2:0]    Occupancy;
   logic [15:0]   PktInCnt;
   logic [15:0]   PktOutCnt;

   local_port_fifo #(.packetwidth(PW), .DEPTH(DEPTH), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
      .GntUpStr(GntUpStr), .Full(Full), .ReqDnStr(ReqDnStr), .PacketOut(PacketOut),
      .GntDnStr(GntDnStr), .Occupancy(Occupancy), .PktInCnt(PktInCnt), .PktOutCnt(PktOutCnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // reference model: ordered packet list plus grant-cycle flag
   logic [PW-1:0] m_q[$];
   logic [PW-1:0] m_last = '0;
   bit            m_gnt = 1'b0;
   logic [15:0]   m_in = '0;
   logic [15:0]   m_out = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_last = '0;
      m_gnt  = 1'b0;
      m_in   = '0;
      m_out  = '0;
   endtask

   // one clock edge worth of the rules, evaluated on pre-edge state
   task automatic model_step(input bit req, input logic [PW-1:0] pkt, input bit gnt);
      bit wr;
      bit pop;
      wr  = req && !m_gnt && (m_q.size() < DEPTH);
      pop = gnt && (m_q.size() != 0);
      if (pop) begin
         m_last = m_q.pop_front();
         m_out  = m_out + 16'd1;
      end
      if (wr) begin
         m_q.push_back(pkt);
         m_in = m_in + 16'd1;
      end
      m_gnt = wr;
   endtask

   task automatic check_all();
      logic [PW-1:0] head;
      head = (m_q.size() != 0) ? m_q[0] : m_last;
      chk("GntUpStr",  64'(GntUpStr),  64'(m_gnt));
      chk("Full",      64'(Full),      64'(m_q.size() == DEPTH));
      chk("ReqDnStr",  64'(ReqDnStr),  64'(m_q.size() != 0));
      chk("PacketOut", 64'(PacketOut), 64'(head));
      chk("Occupancy", 64'(Occupancy), 64'(m_q.size()));
      chk("PktInCnt",  64'(PktInCnt),  STATS ? 64'(m_in)  : 64'd0);
      chk("PktOutCnt", 64'(PktOutCnt), STATS ? 64'(m_out) : 64'd0);
   endtask

   task automatic cycle(input bit req, input logic [PW-1:0] pkt, input bit gnt);
      ReqUpStr = req;
      PacketIn = pkt;
      GntDnStr = gnt;
      model_step(req, pkt, gnt);
      @(negedge clk);
      check_all();
   endtask

   // injector-style push: request held through the grant cycle
   task automatic push(input logic [PW-1:0] pkt, input bit gnt);
      cycle(1'b1, pkt, gnt);
      cycle(1'b1, pkt, 1'b0);
   endtask

   // asynchronous reset pulse between clock edges (called at a falling edge)
   task automatic mid_reset();
      #2;
      ReqUpStr = 1'b0;
      GntDnStr = 1'b0;
      reset    = 1'b0;
      #1;
      model_reset();
      check_all();
      #1 reset = 1'b1;
   endtask

   function automatic logic [PW-1:0] mkpkt(input int id);
      logic [PW-1:0] p;
      p = '0;
      p[25:16] = 10'(id);
      p[15:10] = 6'd1;
      p[9:0]   = 10'(id * 37);
      return p;
   endfunction

   initial begin
      logic [PW-1:0] p0;
      logic [63:0]   r64;
      p0 = 56'h0000_0004_010A00;
      model_reset();
      #1 check_all();
      @(negedge clk);
      reset = 1'b1;

      // single packet with no router grant
      push(p0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      chk("single_head", 64'(PacketOut), 64'(p0));
      cycle(1'b0, '0, 1'b1);

      // fill with IDs 1..4, then a 5th waits for a pop
      for (int i = 1; i <= 4; i++) push(mkpkt(i), 1'b0);
      chk("full_after_4", 64'(Full), 64'd1);
      for (int i = 0; i < 3; i++) cycle(1'b1, mkpkt(5), 1'b0);
      cycle(1'b1, mkpkt(5), 1'b1);
      push(mkpkt(5), 1'b0);
      chk("fifth_accepted", 64'(Occupancy), 64'd4);

      // drain with grant held high
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
      chk("drained_req", 64'(ReqDnStr), 64'd0);

      // simultaneous push/pop at occupancy 2, pointers wrap several times
      push(mkpkt(10), 1'b0);
      push(mkpkt(11), 1'b0);
      for (int i = 0; i < 6; i++) push(mkpkt(20 + i), 1'b1);
      chk("occ_steady", 64'(Occupancy), 64'd2);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

      // reset with 3 entries and a grant in flight
      push(mkpkt(30), 1'b0);
      push(mkpkt(31), 1'b0);
      cycle(1'b1, mkpkt(32), 1'b0);
      chk("pre_reset_gnt", 64'(GntUpStr), 64'd1);
      mid_reset();
      push(mkpkt(40), 1'b0);
      chk("head_after_reset", 64'(PacketOut), 64'(mkpkt(40)));

      // 10 pushes, 7 pops
      mid_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, mkpkt(50 + i), 1'b0);
         cycle(1'b1, mkpkt(50 + i), i < 7);
      end
      chk("stat_in_10",  64'(PktInCnt),  STATS ? 64'd10 : 64'd0);
      chk("stat_out_7",  64'(PktOutCnt), STATS ? 64'd7  : 64'd0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r64 = {$urandom(), $urandom()};
         cycle($urandom_range(0, 3) != 0, r64[PW-1:0], $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) mid_reset();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
